// File: rtl/dcs_ctrl_pkg.sv
// Shared types and helpers for the DCS clock-select control path.
package dcs_ctrl_pkg;

  localparam int NUM_CLK = 4;
  localparam int SEL_W   = 2;

  // Selection FSM states.
  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    GAP       = 2'd1,
    RUN       = 2'd2
  } state_t;

  // Clock index to the one-hot CLKSEL pattern.
  function automatic logic [NUM_CLK-1:0] onehot(input logic [SEL_W-1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/dcs_sel_ctrl_btn_debounce.sv
// One button: 2-FF synchronizer, polarity normalization, debounce counter
// and a single-cycle pulse on each accepted released->pressed transition.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  localparam int             CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  // The synchronizer resets to the raw "released" level so that reset
  // itself never looks like a press to the debounce counter.
  localparam logic           RAW_IDLE = ACTIVE_LOW ? 1'b1 : 1'b0;

  logic             sync1_r;
  logic             sync2_r;
  logic             level_s;
  logic             deb_r;
  logic [CNT_W-1:0] cnt_r;

  assign level_s = ACTIVE_LOW ? ~sync2_r : sync2_r;

  // Bring the raw button into the clk domain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_r <= RAW_IDLE;
      sync2_r <= RAW_IDLE;
    end else begin
      sync1_r <= btn;
      sync2_r <= sync1_r;
    end
  end

  // Accept a new level only after it has held for DEBOUNCE_CYCLES samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb_r <= 1'b0;
      cnt_r <= '0;
      press <= 1'b0;
    end else if (level_s == deb_r) begin
      cnt_r <= '0;
      press <= 1'b0;
    end else if (cnt_r == CNT_LAST) begin
      deb_r <= level_s;
      cnt_r <= '0;
      press <= level_s;
    end else begin
      cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      press <= 1'b0;
    end
  end

endmodule

// File: rtl/dcs_sel_ctrl.sv
// Control stage in front of a 4-input DCS: debounced button requests plus
// PLL lock become a CLKSEL word that is always one-hot or all-zero, with an
// all-zero gap inserted before every new selection.
module dcs_sel_ctrl
  import dcs_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int GAP_CYCLES      = 16,
  parameter int DEFAULT_SEL     = 0,
  parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_CLK-1:0] btn,
  input  logic               lock,
  output logic [NUM_CLK-1:0] clksel,
  output logic [SEL_W-1:0]   sel_idx,
  output logic               busy
);

  localparam int               GAP_W    = $clog2(GAP_CYCLES + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
  localparam logic [SEL_W-1:0] DEF_IDX  = SEL_W'(DEFAULT_SEL);

  logic [NUM_CLK-1:0] press_s;
  logic               evt_s;
  logic [SEL_W-1:0]   evt_idx_s;
  logic [SEL_W-1:0]   next_sel_s;
  logic               lock1_r;
  logic               lock2_r;
  logic [GAP_W-1:0]   gap_cnt_r;
  state_t             state_r;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CLK; gi++) begin : g_btn
      btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .ACTIVE_LOW      (BTN_ACTIVE_LOW)
      ) u_deb (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn[gi]),
        .press (press_s[gi])
      );
    end
  endgenerate

  // Same-cycle presses resolve to the lowest index.
  always_comb begin
    evt_s     = |press_s;
    evt_idx_s = 2'd0;
    casez (press_s)
      4'b???1: evt_idx_s = 2'd0;
      4'b??10: evt_idx_s = 2'd1;
      4'b?100: evt_idx_s = 2'd2;
      4'b1000: evt_idx_s = 2'd3;
      default: evt_idx_s = 2'd0;
    endcase
  end

  assign next_sel_s = evt_s ? evt_idx_s : sel_idx;

  // Bring PLL lock into the clk domain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock1_r <= 1'b0;
      lock2_r <= 1'b0;
    end else begin
      lock1_r <= lock;
      lock2_r <= lock1_r;
    end
  end

  // Selection FSM: lock loss wins over everything, but a press always
  // retargets sel_idx so the next lock/gap lands on the latest request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= WAIT_LOCK;
      gap_cnt_r <= '0;
      clksel    <= 4'b0000;
      sel_idx   <= DEF_IDX;
      busy      <= 1'b1;
    end else begin
      sel_idx <= next_sel_s;
      if (!lock2_r) begin
        state_r   <= WAIT_LOCK;
        gap_cnt_r <= '0;
        clksel    <= 4'b0000;
        busy      <= 1'b1;
      end else begin
        case (state_r)
          WAIT_LOCK: begin
            state_r   <= GAP;
            gap_cnt_r <= '0;
            clksel    <= 4'b0000;
            busy      <= 1'b1;
          end
          GAP: begin
            if (gap_cnt_r == GAP_LAST) begin
              state_r <= RUN;
              clksel  <= onehot(next_sel_s);
              busy    <= 1'b0;
            end else begin
              gap_cnt_r <= gap_cnt_r + {{(GAP_W-1){1'b0}}, 1'b1};
              clksel    <= 4'b0000;
              busy      <= 1'b1;
            end
          end
          RUN: begin
            if (evt_s && (evt_idx_s != sel_idx)) begin
              state_r   <= GAP;
              gap_cnt_r <= '0;
              clksel    <= 4'b0000;
              busy      <= 1'b1;
            end else begin
              clksel <= onehot(sel_idx);
              busy   <= 1'b0;
            end
          end
          default: begin
            state_r   <= WAIT_LOCK;
            gap_cnt_r <= '0;
            clksel    <= 4'b0000;
            busy      <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dcs_sel_ctrl.sv
// Self-checking bench for dcs_sel_ctrl: directed steps then random buttons
// and lock, compared every cycle against a behavioural reference.
module tb_dcs_sel_ctrl;

  localparam int DEB  = 4;
  localparam int GAPC = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] btn;
  logic       lock;
  logic [3:0] clksel;
  logic [1:0] sel_idx;
  logic       busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dcs_sel_ctrl #(
    .DEBOUNCE_CYCLES (DEB),
    .GAP_CYCLES      (GAPC),
    .DEFAULT_SEL     (0),
    .BTN_ACTIVE_LOW  (1'b1)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .btn     (btn),
    .lock    (lock),
    .clksel  (clksel),
    .sel_idx (sel_idx),
    .busy    (busy)
  );

  // Reference state: sample pipelines, per-button hold runs, selection.
  logic [3:0] m_bs1, m_bs2, m_deb, m_press;
  logic       m_ls1, m_ls2;
  int         m_run [4];
  logic [1:0] m_target;
  bit         m_on;
  int         m_gap_left;

  task automatic model_reset();
    m_bs1 = 4'hF; m_bs2 = 4'hF; m_deb = 4'h0; m_press = 4'h0;
    m_ls1 = 1'b0; m_ls2 = 1'b0;
    for (int i = 0; i < 4; i++) m_run[i] = 0;
    m_target = 2'd0; m_on = 1'b0; m_gap_left = 0;
  endtask

  // Advance the reference by one clock edge using pre-edge values.
  task automatic model_edge();
    bit         evt;
    logic [1:0] idx;
    logic [3:0] np;
    logic       lvl;
    evt = |m_press;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) if (m_press[i]) idx = 2'(i);
    if (!m_ls2) begin
      m_on = 1'b0; m_gap_left = 0;
    end else if (m_on) begin
      if (evt && idx != m_target) begin m_on = 1'b0; m_gap_left = GAPC; end
    end else if (m_gap_left == 0) begin
      m_gap_left = GAPC;
    end else begin
      m_gap_left--;
      if (m_gap_left == 0) m_on = 1'b1;
    end
    if (evt) m_target = idx;
    np = 4'h0;
    for (int i = 0; i < 4; i++) begin
      lvl = ~m_bs2[i];
      if (lvl == m_deb[i]) m_run[i] = 0;
      else begin
        m_run[i]++;
        if (m_run[i] == DEB) begin m_deb[i] = lvl; m_run[i] = 0; np[i] = lvl; end
      end
    end
    m_press = np;
    m_bs2 = m_bs1; m_bs1 = btn;
    m_ls2 = m_ls1; m_ls1 = lock;
  endtask

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  task automatic chk_model();
    chk("clksel", clksel, m_on ? (4'b0001 << m_target) : 4'b0000);
    chk("sel_idx", {2'b00, sel_idx}, {2'b00, m_target});
    chk("busy", {3'b000, busy}, {3'b000, !m_on});
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk_model();
  endtask

  // Invariant monitor: at most one select, and zero gap before any new one-hot.
  logic [3:0] prev_sel = 4'b0000;
  int         zrun     = 0;
  bit         seen_on  = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      total++;
      assert ($countones(clksel) <= 1) else begin
        bad++;
        $error("FAIL popcount: observed %b expected at most one bit", clksel);
      end
      if (clksel != 4'b0000 && prev_sel == 4'b0000 && seen_on) begin
        total++;
        assert (zrun >= GAPC) else begin
          bad++;
          $error("FAIL gap_len: observed %0d expected >= %0d", zrun, GAPC);
        end
      end
      if (clksel != 4'b0000 && prev_sel != 4'b0000) begin
        total++;
        assert (clksel === prev_sel) else begin
          bad++;
          $error("FAIL direct_switch: observed %b expected %b", clksel, prev_sel);
        end
      end
    end
    if (clksel == 4'b0000) zrun++;
    else begin zrun = 0; seen_on = 1'b1; end
    prev_sel = clksel;
  end

  initial begin
    rst = 1'b1; btn = 4'hF; lock = 1'b0;
    model_reset();
    #12 rst = 1'b0;

    // Reset state, no lock for 20 cycles.
    chk("rst_clksel", clksel, 4'b0000);
    chk("rst_busy", {3'b000, busy}, 4'b0001);
    repeat (20) tick();

    // Lock edge: one-hot exactly 2+1+GAPC cycles later.
    lock = 1'b1;
    repeat (5) tick();
    chk("lock_pre", clksel, 4'b0000);
    tick();
    chk("lock_on", clksel, 4'b0001);
    chk("lock_busy", {3'b000, busy}, 4'b0000);

    // Press idx2: event after 2+4, then GAPC zero cycles, then 0100.
    btn = 4'b1011;
    repeat (9) tick();
    chk("sw2_gap", clksel, 4'b0000);
    tick();
    chk("sw2_on", clksel, 4'b0100);
    chk("sw2_idx", {2'b00, sel_idx}, 4'd2);
    btn = 4'hF;
    repeat (8) tick();

    // Glitch on btn[1] shorter than the debounce window.
    btn = 4'b1101;
    repeat (3) tick();
    btn = 4'hF;
    repeat (8) tick();
    chk("glitch", clksel, 4'b0100);

    // idx0 and idx3 together: lowest index wins.
    btn = 4'b0110;
    repeat (10) tick();
    chk("lowest", clksel, 4'b0001);
    btn = 4'hF;
    repeat (8) tick();

    // Re-press current index: no gap.
    btn = 4'b1110;
    repeat (10) tick();
    chk("same_idx", clksel, 4'b0001);
    btn = 4'hF;
    repeat (8) tick();

    // Retarget during GAP: original schedule, new index.
    btn = 4'b1011;
    tick();
    btn = 4'b1001;
    repeat (9) tick();
    chk("retarget", clksel, 4'b0010);
    chk("retarget_idx", {2'b00, sel_idx}, 4'd1);
    btn = 4'hF;
    repeat (8) tick();

    // Lock loss mid-RUN, then re-lock onto last target.
    lock = 1'b0;
    repeat (3) tick();
    chk("unlock", clksel, 4'b0000);
    chk("unlock_busy", {3'b000, busy}, 4'b0001);
    lock = 1'b1;
    repeat (6) tick();
    chk("relock", clksel, 4'b0010);

    // Asynchronous reset in the middle of a GAP.
    btn = 4'b1011;
    repeat (7) tick();
    chk("pre_rst_gap", {3'b000, busy}, 4'b0001);
    btn = 4'hF;
    #2 rst = 1'b1;
    #1;
    chk("arst_clksel", clksel, 4'b0000);
    chk("arst_idx", {2'b00, sel_idx}, 4'd0);
    chk("arst_busy", {3'b000, busy}, 4'b0001);
    model_reset();
    #2 rst = 1'b0;
    repeat (6) tick();
    chk("rst_relock", clksel, 4'b0001);

    // Random buttons and occasional lock drops.
    for (int n = 0; n < 60; n++) begin
      btn  = 4'($urandom);
      lock = ($urandom_range(0, 9) != 0);
      repeat ($urandom_range(1, 8)) tick();
    end
    lock = 1'b1; btn = 4'hF;
    repeat (20) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dcs_sel_ctrl.md
Name: dcs_sel_ctrl

Overview:
- Upstream control stage for the 4-input dynamic clock selector (DCS, RISING mode) fed by PLLA CLKOUT0..3.
- Turns raw board buttons plus PLL lock into a clean CLKSEL word.
- Debounces buttons and turns presses into selection requests.
- Gates all selection until lock is seen; on every change, drives an all-zero gap before the new one-hot so the DCS never sees two active selects.

Parameters:
- DEBOUNCE_CYCLES, 500000, cycles a synchronized button must hold a new level before acceptance (10 ms at 50 MHz)
- GAP_CYCLES, 16, cycles CLKSEL is held all-zero between selections; minimum 1
- DEFAULT_SEL, 0, clock index selected after reset/lock (0..3)
- BTN_ACTIVE_LOW, 1, 1 = pressed button reads 0

Ports:
- clk, input, 1, system clock (50 MHz board clock, not a PLL output)
- rst, input, 1, asynchronous, active-high reset
- btn, input, 4, raw asynchronous buttons; bit i requests clock i
- lock, input, 1, PLL LOCK, asynchronous
- clksel, output, 4, to DCS CLKSEL; one-hot or all-zero
- sel_idx, output, 2, index of the current/target clock
- busy, output, 1, high whenever clksel is all-zero

Behaviour:
- Reset, asynchronous and active-high: clksel=0, sel_idx=DEFAULT_SEL, busy=1, state=WAIT_LOCK, all synchronizers/debounce counters cleared.
- Debounced state resets to "released".
- Synchronization: btn[3:0] and lock each pass through a 2-FF synchronizer. Polarity is normalized after sync: pressed = BTN_ACTIVE_LOW ? ~b : b.
- Debounce, per bit:
  - Counter reloads while the synced value equals the debounced value.
  - Otherwise it counts up; at DEBOUNCE_CYCLES-1 the debounced value flips and the counter clears.
  - Glitches shorter than DEBOUNCE_CYCLES are ignored.
- Press event: a 1-cycle pulse on the debounced released->pressed edge. Multiple same-cycle events resolve to the lowest index. Releases generate nothing.
- FSM states:
  - WAIT_LOCK: clksel=0, busy=1. Press events are ignored, but the latest one still updates sel_idx (target). Synced lock=1 -> GAP, gap counter=0.
  - GAP: clksel=0, busy=1. Counter increments each cycle; at GAP_CYCLES-1 -> RUN. A press event in GAP updates target and does not restart the counter.
  - RUN: clksel = 1<<sel_idx, busy=0. A press event on index j != sel_idx sets sel_idx=j and goes to GAP with counter=0. A press on the current index is ignored.
- Lock loss: synced lock=0 in any state -> WAIT_LOCK on the next edge (clksel=0 next cycle). This takes priority over any simultaneous press transition; the press still updates the target.
- Latency:
  - Press event registered at edge n (state RUN).
  - clksel=0 from edge n+1, for exactly GAP_CYCLES cycles.
  - New one-hot from edge n+1+GAP_CYCLES.
  - Lock: synced rising edge at edge m -> first one-hot at m+1+GAP_CYCLES.
- Outputs are registered (no combinational path input->clksel).
- Invariant: popcount(clksel) <= 1 in every cycle. There is never a direct one-hot->one-hot change without at least GAP_CYCLES zero cycles between.
- Reset mid-GAP or mid-debounce: immediate return to reset values; no partial selection survives.

Decomposition:
- Shared package dcs_ctrl_pkg:
  - NUM_CLK=4, SEL_W=2
  - state enum {WAIT_LOCK, GAP, RUN}
  - onehot function (index -> 4-bit one-hot)
- Sub-module btn_debounce (one bit: sync FFs, counter, debounced level, press pulse; params DEBOUNCE_CYCLES, ACTIVE_LOW), instantiated NUM_CLK times.
- The lock synchronizer and FSM live in dcs_sel_ctrl.

Test Plan (DEBOUNCE_CYCLES=4, GAP_CYCLES=3, DEFAULT_SEL=0, BTN_ACTIVE_LOW=1):
- Reset, btn=4'hF, lock=0 for 20 cycles -> clksel=0, busy=1, sel_idx=0 throughout. Raise lock -> clksel=4'b0001 exactly 2(sync)+1+3 cycles after the lock edge, busy=0.
- In RUN on idx0, drive btn=4'b1011 steady -> after 2+4 cycles a press event; next 3 cycles clksel=0; then clksel=4'b0100, sel_idx=2.
- btn[1] glitch low for 3 cycles -> no event; clksel stays unchanged. Checker asserts popcount(clksel)<=1 and a >=3-cycle zero gap on every change, all tests.
- btn=4'b0110 (idx0 and idx3 pressed same cycle) -> lowest wins, clksel becomes 4'b0001. Pressing idx0 again while on idx0 -> no gap, clksel constant.
- During GAP toward idx2, press idx1 -> gap ends on the original schedule with clksel=4'b0010. Drop lock mid-RUN -> clksel=0 within 3 cycles, WAIT_LOCK; re-lock -> resumes on the last target.
- Assert rst during GAP -> clksel=0, sel_idx=0, busy=1 in the same cycle (asynchronous); after release, the lock sequence repeats.
